// File: rtl/line_fetch_pkg.sv
// Shared types and helpers for the line fetch / BCD conversion engine.
package line_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      CONV,
      STORE
   } state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   function automatic int unsigned pow10(input int unsigned d);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Sequential double-dabble converter: load a binary value, then one add-3/shift per step.
module bcd_dd_seq
   import line_fetch_pkg::*;
#(
   parameter int unsigned N      = 10,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [N-1:0]          din,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic                  done
);

   localparam int unsigned W     = 4*DIGITS + N;
   localparam int unsigned CW    = $clog2(N + 1);
   localparam int unsigned LIMIT = pow10(DIGITS);

   logic [W-1:0]  sh;
   logic [W-1:0]  adj;
   logic [CW-1:0] cnt;

   always_comb begin
      adj = sh;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sh[N+4*i +: 4] >= 4'd5) adj[N+4*i +: 4] = sh[N+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (load) begin
         sh  <= W'(din);
         cnt <= CW'(N);
         ovf <= (64'(din) >= 64'(LIMIT));
      end else if (step && (cnt != '0)) begin
         sh  <= adj << 1;
         cnt <= cnt - CW'(1);
      end
   end

   assign bcd  = sh[W-1 -: 4*DIGITS];
   // High during the final step; the result is valid from the following edge.
   assign done = (cnt == CW'(1));

endmodule

// File: rtl/line_fetch_bcd.sv
// Fetches one text line of binary values, converts each to BCD and double-buffers the line.
// Optional macro LINE_FETCH_BLANK_LZ_EN blanks leading zero digits of each value.
module line_fetch_bcd
   import line_fetch_pkg::*;
#(
   parameter int unsigned N          = 10,
   parameter int unsigned DIGITS     = 3,
   parameter int unsigned HCHAR      = 48,
   parameter int unsigned ADR_BITS   = 6,
   parameter int unsigned LINE_BITS  = 5,
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [3:0]  OVF_CODE   = 4'hE
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  start,
   input  logic [LINE_BITS-1:0]  line_idx,
   input  logic [ADR_BITS-1:0]   base_addr,
   input  logic                  swap,
   output logic                  rd_en,
   output logic [ADR_BITS-1:0]   rd_addr,
   input  logic [N-1:0]          rd_data,
   output logic [4*HCHAR-1:0]    lineout,
   output logic                  ready,
   output logic                  busy,
   output logic                  err_miss
);

   localparam int unsigned VPL = HCHAR / DIGITS;
   localparam int unsigned GW  = 4 * DIGITS;
   localparam int unsigned KW  = (VPL > 1) ? $clog2(VPL) : 1;

   state_t              state, nxt;
   logic [KW-1:0]       k;
   logic [ADR_BITS-1:0] addr;
   logic [ADR_BITS-1:0] start_addr;
   logic [2:0]          wcnt;
   logic [GW-1:0]       back [VPL];
   logic                conv_load, conv_step, conv_done, conv_ovf;
   logic [GW-1:0]       conv_bcd;
   logic [GW-1:0]       group;

   assign start_addr = base_addr + ADR_BITS'(32'(line_idx) * VPL);
   assign busy       = (state != IDLE);

   bcd_dd_seq #(
      .N      (N),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk  (clk),
      .rst  (RST),
      .load (conv_load),
      .step (conv_step),
      .din  (rd_data),
      .bcd  (conv_bcd),
      .ovf  (conv_ovf),
      .done (conv_done)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt       = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      conv_load = 1'b0;
      conv_step = 1'b0;
      case (state)
         IDLE:  if (start) nxt = READ;
         READ: begin
            rd_en   = 1'b1;
            rd_addr = addr + ADR_BITS'(k);
            nxt     = WAIT;
         end
         WAIT: begin
            if (wcnt == '0) begin
               conv_load = 1'b1;
               nxt       = CONV;
            end
         end
         CONV: begin
            conv_step = 1'b1;
            if (conv_done) nxt = STORE;
         end
         STORE: nxt = (k == KW'(VPL - 1)) ? IDLE : READ;
         default: nxt = IDLE;
      endcase
   end

`ifdef LINE_FETCH_BLANK_LZ_EN
   logic lead;
`endif

   always_comb begin
      group = conv_ovf ? {DIGITS{OVF_CODE}} : conv_bcd;
`ifdef LINE_FETCH_BLANK_LZ_EN
      lead = 1'b1;
      // Least significant digit is excluded from the scan so zero stays visible.
      if (!conv_ovf) begin
         for (int unsigned j = 0; j < DIGITS - 1; j++) begin
            if (lead && (conv_bcd[GW-1-4*j -: 4] == 4'd0)) group[GW-1-4*j -: 4] = BLANK_CODE;
            else lead = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         k        <= '0;
         addr     <= '0;
         wcnt     <= '0;
         ready    <= 1'b0;
         err_miss <= 1'b0;
         lineout  <= '1;
         for (int unsigned i = 0; i < VPL; i++) back[i] <= '1;
      end else begin
         err_miss <= swap && !ready;
         // Swap is evaluated before the IDLE start branch, so a same-edge start refills safely.
         if (swap && ready) begin
            ready <= 1'b0;
            for (int unsigned i = 0; i < VPL; i++) lineout[4*HCHAR-1-GW*i -: GW] <= back[i];
         end
         case (state)
            IDLE: begin
               if (start) begin
                  addr  <= start_addr;
                  k     <= '0;
                  ready <= 1'b0;
               end
            end
            READ: wcnt <= 3'(RD_LATENCY - 1);
            WAIT: if (wcnt != '0) wcnt <= wcnt - 3'd1;
            STORE: begin
               back[k] <= group;
               if (k == KW'(VPL - 1)) ready <= 1'b1;
               else                   k     <= k + KW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/line_fetch_bcd.md
Name: line_fetch_bcd

Overview:
- Per-text-line fetch and convert engine for the VGA character display.
- On a start pulse it reads one row of binary values from the value memory, converts each to packed BCD with a sequential double-dabble, and packs the digits into a back line buffer.
- The filled line is swapped into the display line buffer that feeds the glyph renderer.
- Value width, digits per value, characters per line and memory read latency are all parameters.

Parameters:
- N, 10: width of each binary value read from memory.
- DIGITS, 3: decimal digits (4-bit codes) produced per value.
- HCHAR, 48: characters per text line; must be a multiple of DIGITS. VPL = HCHAR/DIGITS values per line (localparam).
- ADR_BITS, 6: value memory address width.
- LINE_BITS, 5: width of the line index input.
- RD_LATENCY, 1: cycles from rd_en to rd_data valid; legal range 1..4.
- OVF_CODE, 4'hE: digit code written to every digit of a value that does not fit in DIGITS digits.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- RST, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins filling the back buffer.
- line_idx, input, LINE_BITS: text line to fetch; sampled when start is accepted.
- base_addr, input, ADR_BITS: address of value 0 of line 0; sampled when start is accepted.
- swap, input, 1: request to present the back buffer, issued at end of the active line.
- rd_en, output, 1: memory read strobe.
- rd_addr, output, ADR_BITS: memory read address.
- rd_data, input, N: memory data, valid RD_LATENCY cycles after rd_en.
- lineout, output, 4*HCHAR: display buffer; character 0 occupies the top nibble.
- ready, output, 1: back buffer is completely filled and not yet swapped.
- busy, output, 1: FSM is not in IDLE.
- err_miss, output, 1: one-cycle pulse when a swap arrives while ready is 0.

Behaviour:
- Reset values: lineout all 4'hF (blank), both buffers cleared to the same value, FSM IDLE, rd_en 0, rd_addr 0, ready 0, busy 0, err_miss 0.
- Reset asserted mid-fill aborts immediately. No partial line ever reaches lineout.
- FSM states: IDLE, READ, WAIT, CONV, STORE.
- IDLE, on start: latch addr = base_addr + line_idx*VPL, computed modulo 2^ADR_BITS. Set value index k = 0, clear ready, go to READ.
- READ: rd_en = 1 for exactly one cycle with rd_addr = addr + k. Go to WAIT.
- WAIT: hold for RD_LATENCY cycles, then capture rd_data into a shift register. Go to CONV.
- CONV: N cycles of double-dabble. In each cycle, add 3 to every BCD nibble that is >= 5, then shift left by one.
- CONV overflow: if the captured value >= 10^DIGITS (localparam), every digit becomes OVF_CODE.
- STORE: write the DIGITS nibbles into back-buffer character slots k*DIGITS .. k*DIGITS+DIGITS-1, most significant digit first.
- STORE exit: if k == VPL-1, set ready = 1 and go to IDLE; otherwise k = k+1 and go to READ.
- Fill latency per line: VPL*(RD_LATENCY + N + 2) cycles from start acceptance to ready; 208 cycles at the defaults.
- start while busy: ignored. The current fill continues unaffected.
- swap with ready = 1: lineout takes the back buffer on the next edge and ready clears.
- swap with ready = 0: lineout is unchanged and err_miss pulses.
- swap and start in the same cycle with ready = 1: the swap is applied first, then the new fill starts in the same edge.
- Address wrap: addr + k wraps modulo 2^ADR_BITS with no error.

Optional Feature:
- Macro: LINE_FETCH_BLANK_LZ_EN.
- Defined: in STORE, leading zero digits of each value are replaced by 4'hF (blank). The least significant digit is never blanked, so 0 renders as "  0".
- Overflowed values are not blanked.
- Not defined: all digits are written as converted, so 7 renders as "007".

Decomposition:
- Shared package line_fetch_pkg holds:
  - FSM state enum.
  - Blank code 4'hF.
  - Function pow10(DIGITS), used for the overflow limit.
- Sub-module bcd_dd_seq: a load/step/done sequential double-dabble converter with parameters N and DIGITS. The FSM drives it during CONV.

Test Plan:
- Reset, then probe: lineout all ones, ready 0, rd_en 0; assert RST in the middle of a fill and confirm the same state immediately.
- Memory preloaded with k*7 at address k, base_addr 0, line_idx 1, start: rd_addr runs 16..31, ready rises after 208 cycles; after swap, lineout top 12 bits are 0x112 (value 112) and bottom 12 bits are 0x217.
- rd_data 1023 with DIGITS 3: the slot holds 0xEEE; rd_data 999: the slot holds 0x999.
- swap with ready 0 -> err_miss pulses for exactly 1 cycle and lineout is unchanged; start while busy -> rd_addr sequence is unchanged.
- base_addr 60, line_idx 0: rd_addr reads 60, 61, 62, 63, 0, 1 ... 11 (wrap).
- With LINE_FETCH_BLANK_LZ_EN defined, values 7 and 0 -> slots 0xFF7 and 0xFF0; with it undefined -> 0x007 and 0x000.
